// File: rtl/vx_mem_responder_pkg.sv
// Shared types and helpers for on-chip memory models.
package vx_mem_responder_pkg;

  // Default geometry shared by memory models built from this slice.
  localparam int VX_MEM_DATA_WIDTH = 512;
  localparam int VX_MEM_ADDR_WIDTH = 10;
  localparam int VX_MEM_TAG_WIDTH  = 8;

  // Response entry at default geometry: read data plus the originating tag.
  typedef struct packed {
    logic [VX_MEM_DATA_WIDTH-1:0] data;
    logic [VX_MEM_TAG_WIDTH-1:0]  tag;
  } vx_mem_rsp_t;

  // Counter width able to hold 0..depth inclusive.
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/vx_mem_responder_if.sv
// Memory request / response channel bundle.
// master = requester (core/cache side), slave = memory side.
interface vx_mem_responder_if
  import vx_mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH = VX_MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = VX_MEM_ADDR_WIDTH,
  parameter int TAG_WIDTH  = VX_MEM_TAG_WIDTH
) ();

  logic                    mem_req_valid;
  logic                    mem_req_rw;
  logic [ADDR_WIDTH-1:0]   mem_req_addr;
  logic [DATA_WIDTH/8-1:0] mem_req_byteen;
  logic [DATA_WIDTH-1:0]   mem_req_data;
  logic [TAG_WIDTH-1:0]    mem_req_tag;
  logic                    mem_req_ready;

  logic                    mem_rsp_valid;
  logic [DATA_WIDTH-1:0]   mem_rsp_data;
  logic [TAG_WIDTH-1:0]    mem_rsp_tag;
  logic                    mem_rsp_ready;

  modport master (
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_byteen,
           mem_req_data, mem_req_tag,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    output mem_rsp_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_byteen,
           mem_req_data, mem_req_tag,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    input  mem_rsp_ready
  );

endinterface

// File: rtl/vx_mem_responder_fifo.sv
// Generic circular FIFO; head is presented combinationally on data_out.
// Callers guarantee no push when full and no pop when empty.
module vx_mem_responder_fifo #(
  parameter int DATAW = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] data_out,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DATAW-1:0] store_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer wrap and occupancy update; push and pop in one cycle both apply.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) store_q[wr_ptr_q] <= data_in;
  end

  assign data_out = store_q[rd_ptr_q];
  assign empty    = (count_q == '0);

endmodule

// File: rtl/vx_mem_responder.sv
// Memory-side responder: word-addressed RAM behind a ready/valid request
// channel, returning read data in order after a fixed latency.
module vx_mem_responder
  import vx_mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH     = VX_MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH     = VX_MEM_ADDR_WIDTH,
  parameter int TAG_WIDTH      = VX_MEM_TAG_WIDTH,
  parameter int LATENCY        = 4,
  parameter int RSP_QUEUE_SIZE = 8
) (
  input  logic                clk,
  input  logic                reset,
  vx_mem_responder_if.slave   mem_if
);

  localparam int BYTEEN_WIDTH = DATA_WIDTH / 8;
  localparam int CREDIT_WIDTH = credit_width(RSP_QUEUE_SIZE);
  localparam int ENTRY_WIDTH  = DATA_WIDTH + TAG_WIDTH;
  localparam int RAM_DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(RSP_QUEUE_SIZE);

  // Same layout as vx_mem_rsp_t, sized to this instance.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;
  } rsp_entry_t;

  logic req_fire, rd_fire, wr_fire, rsp_fire;

  logic [DATA_WIDTH-1:0] ram [RAM_DEPTH];

  logic [LATENCY-1:0]              vld_pipe_q, vld_pipe_d;
  rsp_entry_t [LATENCY-1:0]        dat_pipe_q;
  logic [CREDIT_WIDTH-1:0]         credit_q, credit_d;

  logic                            q_empty;
  logic [ENTRY_WIDTH-1:0]          q_head;
  rsp_entry_t                      head;

  // Ready depends only on the credit register, never on mem_req_valid.
  assign mem_if.mem_req_ready = (credit_q < CREDIT_MAX);

  assign req_fire = mem_if.mem_req_valid && mem_if.mem_req_ready;
  assign wr_fire  = req_fire &&  mem_if.mem_req_rw;
  assign rd_fire  = req_fire && !mem_if.mem_req_rw;
  assign rsp_fire = mem_if.mem_rsp_valid && mem_if.mem_rsp_ready;

  // Byte-enabled RAM write at the accept edge.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < BYTEEN_WIDTH; i++) begin
        if (mem_if.mem_req_byteen[i])
          ram[mem_if.mem_req_addr][i*8 +: 8] <= mem_if.mem_req_data[i*8 +: 8];
      end
    end
  end

  // Read sample into pipe stage 0, then advance only occupied stages.
  always_ff @(posedge clk) begin
    if (rd_fire)
      dat_pipe_q[0] <= '{data: ram[mem_if.mem_req_addr], tag: mem_if.mem_req_tag};
    for (int i = 1; i < LATENCY; i++) begin
      if (vld_pipe_q[i-1]) dat_pipe_q[i] <= dat_pipe_q[i-1];
    end
  end

  // Valid shift: a read enters at stage 0 and exits to the queue at the end.
  always_comb begin
    vld_pipe_d    = '0;
    vld_pipe_d[0] = rd_fire;
    for (int i = 1; i < LATENCY; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
  end

  // Outstanding-read credit: +1 per read accept, -1 per response handshake.
  always_comb begin
    credit_d = credit_q;
    case ({rd_fire, rsp_fire})
      2'b10:   credit_d = credit_q + CREDIT_WIDTH'(1);
      2'b01:   credit_d = credit_q - CREDIT_WIDTH'(1);
      default: credit_d = credit_q;
    endcase
  end

  // Pipe valids and credit counter; reset drops every in-flight read.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q <= '0;
      credit_q   <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      credit_q   <= credit_d;
    end
  end

  // Credit limit equals queue depth, so the push below never sees a full queue.
  vx_mem_responder_fifo #(
    .DATAW (ENTRY_WIDTH),
    .DEPTH (RSP_QUEUE_SIZE)
  ) u_rsp_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (vld_pipe_q[LATENCY-1]),
    .pop      (rsp_fire),
    .data_in  (dat_pipe_q[LATENCY-1]),
    .data_out (q_head),
    .empty    (q_empty)
  );

  assign head                 = rsp_entry_t'(q_head);
  assign mem_if.mem_rsp_valid = !q_empty;
  assign mem_if.mem_rsp_data  = head.data;
  assign mem_if.mem_rsp_tag   = head.tag;

endmodule

// File: tb/tb_vx_mem_responder.sv
// Scoreboard bench for vx_mem_responder: expected responses are queued at
// read accept and checked in order at each response handshake.
module tb_vx_mem_responder;
  import vx_mem_responder_pkg::*;

  localparam int DW  = 512;
  localparam int AW  = 10;
  localparam int TW  = 8;
  localparam int BW  = DW / 8;
  localparam int LAT = 4;
  localparam int QS  = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vx_mem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) mem_if ();

  vx_mem_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
    .LATENCY(LAT), .RSP_QUEUE_SIZE(QS)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .mem_if (mem_if)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t          sb[$];
  int            rsp_cycs[$];
  logic [DW-1:0] ref_mem [int];
  int cyc = 0;
  int n_tests = 0, n_fail = 0;
  int n_rsp = 0, n_rd = 0;
  int acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor: every handshake must match the scoreboard head.
  always @(negedge clk) begin
    if (!reset && mem_if.mem_rsp_valid && mem_if.mem_rsp_ready) begin
      n_rsp++;
      rsp_cycs.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_rsp", DW'(mem_if.mem_rsp_tag), DW'(-1));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_tag", DW'(mem_if.mem_rsp_tag), DW'(e.tag));
        chk("rsp_data", mem_if.mem_rsp_data, e.data);
      end
    end
  end

  function automatic void model_accept(input logic rw, input logic [AW-1:0] a,
      input logic [BW-1:0] be, input logic [DW-1:0] d, input logic [TW-1:0] t);
    exp_t e;
    logic [DW-1:0] w;
    if (rw) begin
      w = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
      for (int i = 0; i < BW; i++) if (be[i]) w[i*8 +: 8] = d[i*8 +: 8];
      ref_mem[int'(a)] = w;
    end else begin
      e.data = ref_mem[int'(a)];
      e.tag  = t;
      sb.push_back(e);
      n_rd++;
    end
  endfunction

  // Entered at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic send(input logic rw, input logic [AW-1:0] a, input logic [BW-1:0] be,
      input logic [DW-1:0] d, input logic [TW-1:0] t);
    int n = 0;
    mem_if.mem_req_valid  = 1'b1;
    mem_if.mem_req_rw     = rw;
    mem_if.mem_req_addr   = a;
    mem_if.mem_req_byteen = be;
    mem_if.mem_req_data   = d;
    mem_if.mem_req_tag    = t;
    @(negedge clk);
    while (!mem_if.mem_req_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!mem_if.mem_req_ready) chk("req_accept_timeout", DW'(mem_if.mem_req_ready), DW'(1));
    else model_accept(rw, a, be, d, t);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    mem_if.mem_req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk("drain", DW'(sb.size()), DW'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc, k, ti;
    logic [DW-1:0] h_data;
    logic [TW-1:0] h_tag;
    logic [BW-1:0] all_be;
    logic [DW-1:0] d;
    all_be = '1;

    mem_if.mem_req_valid  = 1'b0;
    mem_if.mem_req_rw     = 1'b0;
    mem_if.mem_req_addr   = '0;
    mem_if.mem_req_byteen = '0;
    mem_if.mem_req_data   = '0;
    mem_if.mem_req_tag    = '0;
    mem_if.mem_rsp_ready  = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", DW'(mem_if.mem_req_ready), DW'(1));
    chk("rst_rsp_valid", DW'(mem_if.mem_rsp_valid), DW'(0));
    @(posedge clk);
    #1;

    // Write then read: exact latency with an empty queue.
    send(1'b1, 10'd5, all_be, {BW{8'hA5}}, 8'd3);
    send(1'b0, 10'd5, '0, '0, 8'd7);
    n = 0;
    @(negedge clk);
    while (!mem_if.mem_rsp_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("rd_latency", DW'(cyc - acc_cyc), DW'(LAT));
    chk("rd_data_a5", mem_if.mem_rsp_data, {BW{8'hA5}});
    @(posedge clk);
    #1;
    drain();

    // Partial write: only byte 0 updated.
    send(1'b1, 10'd2, all_be, '0, 8'd1);
    send(1'b1, 10'd2, BW'(1), '1, 8'd2);
    send(1'b0, 10'd2, '0, '0, 8'd9);
    drain();
    chk("partial_model", ref_mem[2], DW'(8'hFF));

    // Fill addresses used by the bulk phases.
    for (int i = 0; i < 20; i++) begin
      d = {16{$urandom}};
      send(1'b1, AW'(16 + i), all_be, d, TW'(i));
    end

    // Backpressure: 10 reads offered with the consumer stalled.
    mem_if.mem_rsp_ready = 1'b0;
    ti = 0;
    acc = 0;
    mem_if.mem_req_valid  = 1'b1;
    mem_if.mem_req_rw     = 1'b0;
    mem_if.mem_req_addr   = AW'(16);
    mem_if.mem_req_tag    = TW'(0);
    for (int c = 0; c < 16; c++) begin
      logic took;
      @(negedge clk);
      took = mem_if.mem_req_ready;
      if (took) begin
        model_accept(1'b0, mem_if.mem_req_addr, '0, '0, mem_if.mem_req_tag);
        acc++;
      end
      @(posedge clk);
      #1;
      if (took) begin
        ti++;
        mem_if.mem_req_addr = AW'(16 + ti);
        mem_if.mem_req_tag  = TW'(ti);
      end
    end
    chk("full_accepts", DW'(acc), DW'(QS));
    @(negedge clk);
    chk("full_req_ready", DW'(mem_if.mem_req_ready), DW'(0));
    chk("full_rsp_valid", DW'(mem_if.mem_rsp_valid), DW'(1));
    h_data = mem_if.mem_rsp_data;
    h_tag  = mem_if.mem_rsp_tag;
    chk("stall_head_tag", DW'(h_tag), DW'(0));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_tag", DW'(mem_if.mem_rsp_tag), DW'(h_tag));
      chk("stall_data", mem_if.mem_rsp_data, h_data);
      chk("stall_valid", DW'(mem_if.mem_rsp_valid), DW'(1));
    end
    @(posedge clk);
    #1;
    mem_if.mem_rsp_ready = 1'b1;
    k = 0;
    while (ti < 10 && k < 30) begin
      logic took;
      @(negedge clk);
      if (k == 0) chk("ready_at_pop", DW'(mem_if.mem_req_ready), DW'(0));
      else if (k < 3) chk("ready_after_pop", DW'(mem_if.mem_req_ready), DW'(1));
      took = mem_if.mem_req_ready;
      if (took) model_accept(1'b0, mem_if.mem_req_addr, '0, '0, mem_if.mem_req_tag);
      @(posedge clk);
      #1;
      if (took) begin
        ti++;
        if (ti == 10) mem_if.mem_req_valid = 1'b0;
        else begin
          mem_if.mem_req_addr = AW'(16 + ti);
          mem_if.mem_req_tag  = TW'(ti);
        end
      end
      k++;
    end
    mem_if.mem_req_valid = 1'b0;
    chk("backlog_accepted", DW'(ti), DW'(10));
    drain();

    // Back-to-back throughput.
    rsp_cycs.delete();
    for (int i = 0; i < 20; i++) send(1'b0, AW'(16 + i), '0, '0, TW'(100 + i));
    drain();
    chk("b2b_count", DW'(rsp_cycs.size()), DW'(20));
    if (rsp_cycs.size() == 20)
      chk("b2b_span", DW'(rsp_cycs[19] - rsp_cycs[0]), DW'(19));

    // Reset with 2 queued and 3 in the pipe.
    mem_if.mem_rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(1'b0, AW'(16 + i), '0, '0, TW'(200 + i));
    @(posedge clk);
    #1;
    chk("pre_rst_valid", DW'(mem_if.mem_rsp_valid), DW'(1));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    n_rd -= 5;
    @(negedge clk);
    chk("mid_rst_valid", DW'(mem_if.mem_rsp_valid), DW'(0));
    chk("mid_rst_ready", DW'(mem_if.mem_req_ready), DW'(1));
    @(posedge clk);
    #1;
    mem_if.mem_rsp_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    send(1'b0, 10'd5, '0, '0, 8'd55);
    drain();

    chk("rsp_count", DW'(n_rsp), DW'(n_rd));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
